// File: rtl/signed_seq_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Signed operation uses sign-magnitude: take magnitudes, multiply unsigned, negate the product if needed.
module signed_seq_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      IDLE,
      ABS,
      MUL,
      SIGN,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]   a_reg, b_reg, mplier;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               sm_reg, neg;
   logic [2*WIDTH-1:0] mcand, acc, prod_reg;
   logic [CW-1:0]      cnt;
   logic               accept, last_iter;

   assign accept    = in_valid & in_ready;
   assign last_iter = (cnt == CW'(WIDTH - 1));

   // Most negative input maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
   assign abs_a = (sm_reg & a_reg[WIDTH-1]) ? (~a_reg + WIDTH'(1)) : a_reg;
   assign abs_b = (sm_reg & b_reg[WIDTH-1]) ? (~b_reg + WIDTH'(1)) : b_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ABS;
         ABS:     state_nxt = MUL;
         MUL:     if (last_iter) state_nxt = SIGN;
         SIGN:    state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sm_reg   <= 1'b0;
         neg      <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         prod_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg  <= a;
                  b_reg  <= b;
                  sm_reg <= signed_mode;
               end
            end
            ABS: begin
               mcand  <= {{WIDTH{1'b0}}, abs_a};
               mplier <= abs_b;
               neg    <= sm_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
               acc    <= '0;
               cnt    <= '0;
            end
            MUL: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
            end
            SIGN: begin
               // Negating a zero accumulator wraps back to zero.
               prod_reg <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
            end
            default: ;
         endcase
      end
   end

   assign product = prod_reg;

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Scoreboard bench for signed_seq_multiplier: 8-bit and 16-bit instances, directed vectors.
// Stimulus pushes expected products; per-instance monitors pop on each out_valid/out_ready transfer.
module tb_signed_seq_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        iv8, ir8, sm8, ov8, or8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   logic        iv16, ir16, sm16, ov16, or16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   int checks = 0;
   int errors = 0;

   logic [15:0] q8[$];
   logic [31:0] q16[$];

   signed_seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .signed_mode(sm8),
      .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
   );

   signed_seq_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .signed_mode(sm16),
      .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   always @(negedge clk) begin
      if (rst_n && ov8 && or8) begin
         if (q8.size() == 0) fail_now("prod8_unexpected");
         else chk("prod8", {16'h0, p8}, {16'h0, q8.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov16 && or16) begin
         if (q16.size() == 0) fail_now("prod16_unexpected");
         else chk("prod16", p16, q16.pop_front());
      end
   end

   // Handshake one operation, then scramble the operand inputs to prove they were captured.
   task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      while (!ir8 && n < 100) begin @(negedge clk); n++; end
      if (!ir8) fail_now("issue8_ready");
      sm8 = sm; a8 = a; b8 = b; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0; sm8 = ~sm; a8 = 8'h55; b8 = 8'hAA;
   endtask

   task automatic issue16(input logic sm, input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      @(negedge clk);
      while (!ir16 && n < 100) begin @(negedge clk); n++; end
      if (!ir16) fail_now("issue16_ready");
      sm16 = sm; a16 = a; b16 = b; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0; sm16 = ~sm; a16 = 16'h5555; b16 = 16'hAAAA;
   endtask

   // Counts clock edges after the acceptance edge until out_valid is seen.
   task automatic wait_done8(output int lat);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov8 && lat < 100);
      if (!ov8) fail_now("wait_done8");
   endtask

   task automatic wait_done16(output int lat);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov16 && lat < 100);
      if (!ov16) fail_now("wait_done16");
   endtask

   typedef struct {
      logic        sm;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec8_t;

   vec8_t v8[4] = '{
      '{1'b1, 8'h80, 8'h80, 16'h4000},
      '{1'b1, 8'h80, 8'h7F, 16'hC080},
      '{1'b1, 8'hFF, 8'hFF, 16'h0001},
      '{1'b0, 8'hFF, 8'hFF, 16'hFE01}
   };

   initial begin
      int lat;
      rst_n = 1'b0;
      iv8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
      iv16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {31'h0, ir8}, 32'h1);
      chk("rst_out_valid", {31'h0, ov8}, 32'h0);
      chk("rst_busy", {31'h0, busy8}, 32'h0);
      chk("rst_product", {16'h0, p8}, 32'h0);

      // -3 * 5, with out_ready already high before DONE
      issue8(1'b1, 8'hFD, 8'h05);
      q8.push_back(16'hFFF1);
      wait_done8(lat);
      chk("latency8", lat, 32'd10);
      chk("done_in_ready", {31'h0, ir8}, 32'h0);
      @(posedge clk); #1;
      chk("busy_falls", {31'h0, busy8}, 32'h0);
      chk("idle_in_ready", {31'h0, ir8}, 32'h1);
      chk("product_held_idle", {16'h0, p8}, 32'h0000FFF1);

      // Zero product with neg set, held in DONE for five cycles
      or8 = 1'b0;
      issue8(1'b1, 8'h00, 8'h9C);
      q8.push_back(16'h0000);
      wait_done8(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_out_valid", {31'h0, ov8}, 32'h1);
         chk("hold_in_ready", {31'h0, ir8}, 32'h0);
         chk("hold_product", {16'h0, p8}, 32'h0);
      end
      @(posedge clk); #1 or8 = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      chk("hold_release", {31'h0, ov8}, 32'h0);

      for (int i = 0; i < 4; i++) begin
         issue8(v8[i].sm, v8[i].a, v8[i].b);
         q8.push_back(v8[i].p);
         wait_done8(lat);
         chk("latency8_tbl", lat, 32'd10);
      end
      @(posedge clk); #1;

      // Reset pulse during the fourth MUL iteration discards the operation
      issue8(1'b1, 8'h12, 8'h34);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("midrst_in_ready", {31'h0, ir8}, 32'h1);
      chk("midrst_out_valid", {31'h0, ov8}, 32'h0);
      chk("midrst_busy", {31'h0, busy8}, 32'h0);
      chk("midrst_product", {16'h0, p8}, 32'h0);
      repeat (15) @(posedge clk);
      issue8(1'b0, 8'h07, 8'h06);
      q8.push_back(16'h002A);
      wait_done8(lat);
      chk("latency8_post_rst", lat, 32'd10);
      @(posedge clk); #1;

      // 16-bit instance; in_valid toggling while busy must not disturb the result
      issue16(1'b1, 16'h8000, 16'hFFFF);
      q16.push_back(32'h0000_8000);
      fork
         wait_done16(lat);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               iv16 = i[0];
               a16 = 16'($urandom);
               b16 = 16'($urandom);
               sm16 = 1'($urandom);
            end
            @(negedge clk);
            iv16 = 1'b0;
         end
      join
      chk("latency16", lat, 32'd18);
      @(posedge clk); #1;
      chk("busy16_falls", {31'h0, busy16}, 32'h0);

      issue16(1'b0, 16'hFFFF, 16'hFFFF);
      q16.push_back(32'hFFFE_0001);
      wait_done16(lat);
      issue16(1'b1, 16'h1234, 16'hFFFE);
      q16.push_back(32'hFFFF_DB98);
      wait_done16(lat);
      repeat (3) @(posedge clk);

      if (q8.size() != 0) fail_now("q8_not_drained");
      if (q16.size() != 0) fail_now("q16_not_drained");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/signed_seq_multiplier.md
Name: signed_seq_multiplier

Overview:
- Multi-cycle shift-and-add multiplier. Takes WIDTH-bit operands and produces a 2*WIDTH-bit product.
- Runtime mode selects signed (two's complement) or unsigned operation.
- Signed mode works in sign-magnitude: absolute value of each operand, unsigned multiply, then conditional two's-complement negation of the product.
- Generalises the 8-bit-in / 16-bit-out ALU multiply path into a width-parametrised, handshaked, sequential unit for the ALU datapath.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and mode valid this cycle
- in_ready  output  1  unit can accept an operation this cycle
- signed_mode  input  1  1 = operands are two's complement; 0 = unsigned
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product valid; held until accepted
- out_ready  input  1  consumer accepts product this cycle
- product  output  2*WIDTH  result; two's complement when signed_mode was 1
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clk edge with rst_n=0 forces state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, and clears all internal registers.
  - Reset wins over every other event, including mid-operation; any operation in flight is discarded with no output.
- Handshake:
  - An operation is accepted on a clk edge where in_valid=1 and in_ready=1.
  - in_ready=1 only in IDLE.
  - a, b and signed_mode are captured at acceptance; later changes to them are ignored.
- State machine:
  - IDLE: on accept, go to ABS.
  - ABS (1 cycle): if signed_mode and a[WIDTH-1]=1, |a| = ~a+1, else |a| = a; same rule for b.
    - Register neg = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]).
    - Clear the 2*WIDTH accumulator and the iteration counter. Go to MUL.
  - MUL (exactly WIDTH cycles): each cycle, if the multiplier LSB is 1, add the multiplicand (zero-extended to 2*WIDTH) to the accumulator.
    - Shift the multiplicand left by 1 and the multiplier right by 1; counter++.
    - After the WIDTH-th iteration, go to SIGN.
  - SIGN (1 cycle): product = neg ? (~acc + 1) mod 2^(2*WIDTH) : acc. Go to DONE.
  - DONE: out_valid=1; product held stable.
    - When out_ready=1: go to IDLE with out_valid=0 on the next cycle.
    - A new operation can be accepted no earlier than the cycle after the product is accepted.
- Latency: acceptance edge = cycle 0; out_valid rises after the edge at cycle WIDTH+2 and is visible during cycle WIDTH+3. Throughput is one operation per WIDTH+4 cycles minimum.
- Width rules:
  - Magnitudes are WIDTH-bit unsigned, so the most negative input -2^(WIDTH-1) has magnitude 2^(WIDTH-1) with no overflow.
  - The product always fits in 2*WIDTH bits; no overflow flag.
- Boundaries:
  - A negated zero product yields 0, never a "negative zero".
  - in_valid while busy is ignored and does not queue.
  - out_ready held high before DONE has no effect.
  - out_ready=1 in the same cycle DONE is entered completes the transfer in that cycle (out_valid high for exactly one cycle).
  - product retains its last value in IDLE until the next SIGN update.

Test Plan:
- WIDTH=8, signed_mode=1, a=0xFD (-3), b=0x05 -> after WIDTH+3 cycles out_valid=1, product=0xFFF1 (-15); busy falls the cycle after out_ready.
- WIDTH=8, signed_mode=1, a=0x80 (-128), b=0x80 -> product=0x4000 (16384); a=0x80, b=0x7F -> product=0xC080 (-16256).
- WIDTH=8, signed_mode=0, a=0xFF, b=0xFF -> product=0xFE01; same operands with signed_mode=1 -> product=0x0001.
- WIDTH=8, signed_mode=1, a=0x00, b=0x9C -> product=0x0000. Separately, hold out_ready=0 for 5 cycles in DONE -> product stable and out_valid=1 throughout, in_ready=0.
- Pulse rst_n=0 for one cycle during MUL iteration 4 -> next cycle state IDLE, out_valid=0, product=0, in_ready=1. A new op a=0x07, b=0x06 then yields 0x002A.
- WIDTH=16 instance, signed_mode=1, a=0x8000, b=0xFFFF -> product=0x0000_8000 after 19 cycles. Toggle in_valid with new operands while busy -> no effect on the result.
